instr_fetch: RTL

Fetch stage paired with the instruction memory. It owns the program counter, drives the word-addressed memory's byte address, and captures the returned instruction into the IF/ID pipeline register. It handles stall, squash and branch/jump redirect from later stages. It flags faults on out-of-range or misaligned fetches.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/instr_fetch_ifid_reg.sv | 24 ++
 rtl/instr_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID pipeline payload type.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } ifid_t;

endpackage

// File: rtl/instr_fetch_ifid_reg.sv
// IF/ID pipeline register: load a full entry, kill only the valid bit, or hold.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  kill,
  input  ifid_t d,
  output ifid_t q
);

  // kill wins over load so a squash never lets a fetched word through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (kill) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and fills IF/ID,
// honouring redirect > flush > stall priority with sticky fault reporting.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_next;
  logic              in_range;
  logic              advance;
  logic              kill;
  logic              fault_set;
  ifid_t             ifid_d;
  ifid_t             ifid_q;

  assign im_addr  = pc;
  assign in_range = (pc >> 2) < WORD_W'(IM_DEPTH);
  assign advance  = !redirect_valid && !flush && !stall;
  assign kill     = redirect_valid || flush;

  // Out-of-range fetches deliver a NOP marked invalid and leave the PC parked
  assign ifid_d.instr    = in_range ? im_instr : NOP_INSTR;
  assign ifid_d.pc       = pc;
  assign ifid_d.pc_plus4 = pc + PC_STEP;
  assign ifid_d.valid    = in_range;

  assign fault_set = (redirect_valid && (redirect_pc[1:0] != 2'b00)) ||
                     (advance && !in_range);

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (advance && in_range) begin
      pc_next = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc <= pc_next;
      if (fault_set) begin
        fetch_fault <= 1'b1;
      end
      if (advance && in_range && (fetch_count != '1)) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  ifid_reg u_ifid_reg (
    .clk  (clk),
    .rst  (rst),
    .load (advance),
    .kill (kill),
    .d    (ifid_d),
    .q    (ifid_q)
  );

  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;

endmodule
